hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the vector processor.
- Generates the stall_E/flush_E controls consumed by the Decode/Execute pipeline register, plus the Fetch/Decode stall and flush controls.
- Detects load-use hazards between the Decode and Execute stages.
- Sequences multi-beat 128-bit vector memory accesses with an FSM and beat counter.
- Flushes the front end on taken branches.

Parameters:
- REG_W, 4, register index width (matches regScr).
- VBEATS, 4, 32-bit memory beats per 128-bit vector access (>=2).
- CNT_W, 2, beat counter width, equal to clog2(VBEATS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- regA_D  in  REG_W  source register A index of the instruction in Decode.
- regB_D  in  REG_W  source register B index of the instruction in Decode.
- useB_D  in  1  Decode instruction reads source B.
- regScr_E  in  REG_W  destination register index of the instruction in Execute.
- regw_E  in  1  Execute instruction writes a register.
- regmem_E  in  1  Execute instruction is a memory load.
- memw_E  in  1  Execute instruction is a memory store.
- vect_E  in  1  Execute instruction is a vector operation.
- branch_E  in  1  taken branch resolved in Execute.
- mem_ack  in  1  memory completed one 32-bit beat this cycle.
- stall_F  out  1  hold PC/fetch.
- stall_D  out  1  hold the Fetch/Decode register.
- stall_E  out  1  hold the Decode/Execute register.
- flush_D  out  1  clear the Fetch/Decode register.
- flush_E  out  1  clear the Decode/Execute register (insert bubble).
- busy  out  1  vector memory sequence in progress.
- beat_cnt  out  CNT_W  beats acknowledged so far in the current vector access.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, beat_cnt=0.
  - All outputs 0 while rst_n is low, because the combinational outputs are gated by rst_n.
  - Reset in the middle of a VMEM sequence abandons the sequence; no stall persists after release.
- Signal definitions:
  - vmem_E = vect_E & (regmem_E | memw_E).
  - lu_haz = regmem_E & regw_E & ~vect_E & ((regScr_E==regA_D) | (useB_D & regScr_E==regB_D)).
- FSM states: IDLE, VMEM.
  - IDLE: if vmem_E, stall_F=stall_D=stall_E=1 combinationally in the same cycle.
    - If mem_ack and VBEATS>1: beat_cnt<=1 and go to VMEM.
    - Else: go to VMEM with beat_cnt=0.
  - VMEM: stall_F=stall_D=stall_E=1 and busy=1.
    - Each mem_ack increments beat_cnt.
    - On mem_ack with beat_cnt==VBEATS-1: all stalls drop combinationally in that same cycle so Execute advances at the next edge; beat_cnt<=0 and state<=IDLE.
    - With no mem_ack the state holds indefinitely (no timeout).
  - The last-beat cycle is an exact boundary: stall is 0 on the last-ack cycle and 1 on every earlier cycle.
- Load-use (IDLE only, vmem_E=0): lu_haz gives stall_F=stall_D=1 and flush_E=1 for exactly one cycle. No registered state is involved; the bubble clears the hazard on the next cycle.
- Branch: branch_E=1 gives flush_D=1 and flush_E=1 for that cycle.
  - Branch takes priority over load-use: stall_F/stall_D are forced to 0 when branch_E=1.
- Priority rules:
  - stall_E=1 forces flush_E=0, because a flush would destroy the held vector instruction.
  - branch_E is ignored in VMEM, since a branch cannot coexist with a vector memory instruction in Execute.
- mem_ack in IDLE without vmem_E is ignored.
- busy is 1 exactly when state==VMEM.
- beat_cnt is registered and wraps to 0 only through the completion transition.

Decomposition:
- Shared package vp_pkg holds:
  - REG_W and VBEATS constants.
  - hz_state_t enum {IDLE, VMEM}.
  - A hazard_ctrl_t struct bundling the five stall/flush outputs, for pipeline wiring.
- Sub-module vbeat_counter: CNT_W counter with inc/clr inputs and a last flag (cnt==VBEATS-1). It is reused by the memory-side vector sequencer.

Test Plan:
- Reset mid-VMEM:
  - Stimulus: start a vector load, give 2 acks, pulse rst_n low.
  - Required: outputs 0 immediately; after release state=IDLE, beat_cnt=0, busy=0.
- Load-use:
  - Stimulus: regmem_E=1, regw_E=1, regScr_E=4'h3, regA_D=4'h3, vect_E=0.
  - Required: stall_F=stall_D=flush_E=1 for one cycle; stall_E=0. With regA_D=4'h4, useB_D=0: all outputs 0.
- Vector load with acks on consecutive cycles:
  - Stimulus: vect_E=1, regmem_E=1, mem_ack high for 4 consecutive cycles.
  - Required: stall_E=1 for 3 cycles and 0 on the 4th; beat_cnt sequence 1,2,3,0; busy=1 for 3 cycles.
- Vector store with gapped acks:
  - Stimulus: memw_E=1, vect_E=1, acks on cycles 2, 5, 6, 9.
  - Required: stall held through cycle 8 and released on cycle 9; flush_E=0 throughout.
- Taken branch:
  - Stimulus: branch_E=1 together with a load-use match.
  - Required: flush_D=flush_E=1 and stall_F=stall_D=0.
- Stall/flush priority:
  - Stimulus: vmem_E=1, with a load-use-like register match and branch_E=1 asserted during VMEM.
  - Required: flush_E=0 and stall_E=1 throughout.

Source files
------------

// File: rtl/vp_pkg.sv
// Shared vector-processor pipeline types: register/beat sizing, hazard FSM states
// and the bundled stall/flush control word used to wire the pipeline registers.
package vp_pkg;

    localparam int REG_W  = 4;
    localparam int VBEATS = 4;
    localparam int CNT_W  = $clog2(VBEATS);

    typedef enum logic {
        IDLE = 1'b0,
        VMEM = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic stall_F;
        logic stall_D;
        logic stall_E;
        logic flush_D;
        logic flush_E;
    } hazard_ctrl_t;

endpackage

// File: rtl/vbeat_counter.sv
// Beat counter for multi-beat vector memory accesses; o_last flags the final beat.
// Registered count, clear has priority over increment; no backpressure of its own.
module vbeat_counter #(
    parameter int VBEATS = 4,
    parameter int CNT_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == CNT_W'(VBEATS - 1));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and multi-beat vector
// memory stalls. Stalls/flushes are combinational; only the vector sequence is registered.
module hazard_ctrl #(
    parameter int REG_W  = vp_pkg::REG_W,
    parameter int VBEATS = vp_pkg::VBEATS,
    parameter int CNT_W  = vp_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] regA_D,
    input  logic [REG_W-1:0] regB_D,
    input  logic             useB_D,
    input  logic [REG_W-1:0] regScr_E,
    input  logic             regw_E,
    input  logic             regmem_E,
    input  logic             memw_E,
    input  logic             vect_E,
    input  logic             branch_E,
    input  logic             mem_ack,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             flush_D,
    output logic             flush_E,
    output logic             busy,
    output logic [CNT_W-1:0] beat_cnt
);

    import vp_pkg::*;

    hz_state_t    r_state;
    hz_state_t    w_state_nxt;
    hazard_ctrl_t w_ctl;
    logic         w_busy;
    logic         w_vmem;
    logic         w_lu_haz;
    logic         w_last;
    logic         w_done;
    logic         w_inc;

    assign w_vmem   = vect_E & (regmem_E | memw_E);
    assign w_lu_haz = regmem_E & regw_E & ~vect_E &
                      ((regScr_E == regA_D) | (useB_D & (regScr_E == regB_D)));

    // Final acknowledged beat releases the pipeline in the same cycle.
    assign w_done = (r_state == VMEM) & mem_ack & w_last;
    // The very first beat may already be acknowledged while still in IDLE.
    assign w_inc  = mem_ack & ((r_state == VMEM) | w_vmem);

    vbeat_counter #(
        .VBEATS (VBEATS),
        .CNT_W  (CNT_W)
    ) u_vbeat_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_inc  (w_inc),
        .i_clr  (w_done),
        .o_cnt  (beat_cnt),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_vmem) w_state_nxt = VMEM;
            VMEM:    if (w_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Holding a vector op in Execute always masks branch/load-use flushes.
    always_comb begin
        w_ctl  = '0;
        w_busy = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_vmem) begin
                    w_ctl.stall_F = 1'b1;
                    w_ctl.stall_D = 1'b1;
                    w_ctl.stall_E = 1'b1;
                end else if (branch_E) begin
                    w_ctl.flush_D = 1'b1;
                    w_ctl.flush_E = 1'b1;
                end else if (w_lu_haz) begin
                    w_ctl.stall_F = 1'b1;
                    w_ctl.stall_D = 1'b1;
                    w_ctl.flush_E = 1'b1;
                end
            end
            VMEM: begin
                w_busy        = 1'b1;
                w_ctl.stall_F = ~w_done;
                w_ctl.stall_D = ~w_done;
                w_ctl.stall_E = ~w_done;
            end
            default: begin
                w_ctl  = '0;
                w_busy = 1'b0;
            end
        endcase
    end

    assign stall_F = rst_n & w_ctl.stall_F;
    assign stall_D = rst_n & w_ctl.stall_D;
    assign stall_E = rst_n & w_ctl.stall_E;
    assign flush_D = rst_n & w_ctl.flush_D;
    assign flush_E = rst_n & w_ctl.flush_E;
    assign busy    = rst_n & w_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic scored against a
// transaction-level model that tracks "vector access open" and "beats seen so far".
module tb_hazard_ctrl;

    import vp_pkg::*;

    localparam int NB = VBEATS;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REG_W-1:0] regA_D, regB_D, regScr_E;
    logic             useB_D, regw_E, regmem_E, memw_E, vect_E, branch_E, mem_ack;
    logic             stall_F, stall_D, stall_E, flush_D, flush_E, busy;
    logic [CNT_W-1:0] beat_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    bit m_open;
    int m_beats;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .regA_D   (regA_D),
        .regB_D   (regB_D),
        .useB_D   (useB_D),
        .regScr_E (regScr_E),
        .regw_E   (regw_E),
        .regmem_E (regmem_E),
        .memw_E   (memw_E),
        .vect_E   (vect_E),
        .branch_E (branch_E),
        .mem_ack  (mem_ack),
        .stall_F  (stall_F),
        .stall_D  (stall_D),
        .stall_E  (stall_E),
        .flush_D  (flush_D),
        .flush_E  (flush_E),
        .busy     (busy),
        .beat_cnt (beat_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] act_ctl();
        return {stall_F, stall_D, stall_E, flush_D, flush_E, busy};
    endfunction

    // Expected {stall_F, stall_D, stall_E, flush_D, flush_E, busy} from the pipeline rules.
    function automatic logic [5:0] exp_ctl();
        bit vmem, lu, fin;
        vmem = vect_E && (regmem_E || memw_E);
        lu   = regmem_E && regw_E && !vect_E &&
               ((regScr_E == regA_D) || (useB_D && regScr_E == regB_D));
        if (!rst_n) return 6'b000000;
        if (m_open) begin
            fin = mem_ack && (m_beats + 1 == NB);
            return fin ? 6'b000001 : 6'b111001;
        end
        if (vmem)     return 6'b111000;
        if (branch_E) return 6'b000110;
        if (lu)       return 6'b110010;
        return 6'b000000;
    endfunction

    task automatic model_clock();
        if (m_open) begin
            if (mem_ack) begin
                m_beats++;
                if (m_beats == NB) begin
                    m_open  = 1'b0;
                    m_beats = 0;
                end
            end
        end else if (vect_E && (regmem_E || memw_E)) begin
            m_open  = 1'b1;
            m_beats = mem_ack ? 1 : 0;
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the model on the edge.
    task automatic step(input string tag);
        @(negedge clk);
        #1;
        chk({tag, "/ctl"}, 32'(act_ctl()), 32'(exp_ctl()));
        chk({tag, "/cnt"}, 32'(beat_cnt), 32'(m_beats));
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle_inputs();
        regA_D = '0; regB_D = '0; regScr_E = '0; useB_D = 0; regw_E = 0;
        regmem_E = 0; memw_E = 0; vect_E = 0; branch_E = 0; mem_ack = 0;
    endtask

    initial begin
        int exp_cnt[4] = '{1, 2, 3, 0};
        int c;
        rst_n   = 1'b0;
        m_open  = 1'b0;
        m_beats = 0;
        idle_inputs();
        vect_E = 1; regmem_E = 1; branch_E = 1; regw_E = 1;

        @(negedge clk); #1;
        chk("reset_ctl", 32'(act_ctl()), 32'(0));
        chk("reset_cnt", 32'(beat_cnt), 32'(0));
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Load-use on source A, bubble, then a non-matching register.
        regmem_E = 1; regw_E = 1; regScr_E = 4'h3; regA_D = 4'h3;
        #2 chk("lu_hit", 32'({stall_F, stall_D, stall_E, flush_E}), 32'(4'b1101));
        step("lu");
        regmem_E = 0;
        step("lu_bubble");
        regmem_E = 1; regA_D = 4'h4; useB_D = 0;
        #2 chk("lu_miss", 32'(act_ctl()), 32'(0));
        step("lu_miss");
        useB_D = 1; regB_D = 4'h3;
        step("lu_srcb");
        idle_inputs();

        // Vector load, acks every cycle.
        vect_E = 1; regmem_E = 1; mem_ack = 1;
        for (int i = 0; i < 4; i++) begin
            #2 chk("vld_stallE", 32'(stall_E), 32'(i < 3));
            chk("vld_busy", 32'(busy), 32'(i > 0));
            step("vld");
            chk("vld_cnt", 32'(beat_cnt), 32'(exp_cnt[i]));
        end
        idle_inputs();
        step("vld_after");

        // Vector store, gapped acks.
        vect_E = 1; memw_E = 1;
        for (c = 1; c <= 9; c++) begin
            mem_ack = (c == 2 || c == 5 || c == 6 || c == 9);
            #2 chk("vst_stallE", 32'(stall_E), 32'(c < 9));
            chk("vst_flushE", 32'(flush_E), 32'(0));
            step("vst");
        end
        idle_inputs();
        chk("vst_done", 32'({busy, beat_cnt}), 32'(0));
        step("vst_after");

        // Taken branch overrides a load-use match.
        regmem_E = 1; regw_E = 1; regScr_E = 4'h3; regA_D = 4'h3; branch_E = 1;
        #2 chk("br", 32'({stall_F, stall_D, flush_D, flush_E}), 32'(4'b0011));
        step("br");
        idle_inputs();

        // Vector op held while branch and a register match are presented.
        vect_E = 1; regmem_E = 1; regw_E = 1; regScr_E = 4'h3; regA_D = 4'h3;
        step("prio_start");
        branch_E = 1;
        for (int i = 0; i < 3; i++) begin
            #2 chk("prio_hold", 32'({stall_E, flush_E, flush_D}), 32'(3'b100));
            step("prio");
        end
        branch_E = 0; mem_ack = 1;
        for (int i = 0; i < NB; i++) step("prio_drain");
        idle_inputs();
        step("prio_after");

        // Reset while mid-sequence.
        vect_E = 1; regmem_E = 1;
        step("rst_start");
        mem_ack = 1;
        step("rst_ack1");
        step("rst_ack2");
        idle_inputs();
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1 chk("rst_mid_ctl", 32'(act_ctl()), 32'(0));
        chk("rst_mid_cnt", 32'(beat_cnt), 32'(0));
        m_open = 1'b0; m_beats = 0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_rel", 32'({busy, stall_E, beat_cnt}), 32'(0));
        step("rst_after");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            vect_E   = ($urandom % 4) == 0;
            regmem_E = $urandom % 2;
            memw_E   = $urandom % 2;
            regw_E   = $urandom % 2;
            useB_D   = $urandom % 2;
            branch_E = ($urandom % 6) == 0;
            mem_ack  = $urandom % 2;
            regA_D   = REG_W'($urandom_range(0, 3));
            regB_D   = REG_W'($urandom_range(0, 3));
            regScr_E = REG_W'($urandom_range(0, 3));
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
